// File: rtl/axi_byte_lane_addresser.sv
// Byte address + size onto an AXI data bus: aligned address, strobes, write replication, read extraction.
// Latency 0 (OUTPUT_REG=0) or 1 cycle (OUTPUT_REG=1); no handshake, no backpressure.
module axi_byte_lane_addresser #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter bit OUTPUT_REG = 1'b0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [1:0]              size,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    output logic [ADDR_WIDTH-1:0]   addr_out,
    output logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [DATA_WIDTH-1:0]   wdata_out,
    output logic                    err
);
    localparam int N = DATA_WIDTH / 8;
    localparam int L = $clog2(N);
    localparam logic [3:0] N_LANES = 4'(N);

    logic [3:0]            w_lane;
    logic [3:0]            w_bytes;
    logic [3:0]            w_bmask;
    logic                  w_too_big;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [N-1:0]          w_strb;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] w_wdata;

    always_comb begin
        w_lane          = '0;
        w_lane[L-1:0]   = addr_in[L-1:0];
        w_bytes         = 4'd1 << size;
        w_bmask         = w_bytes - 4'd1;
        w_too_big       = w_bytes > N_LANES;
        w_err           = w_too_big || ((w_lane & w_bmask) != 4'd0);

        w_addr          = addr_in;
        w_addr[L-1:0]   = '0;

        w_shifted       = data_in >> {w_lane, 3'b000};

        w_strb          = '0;
        for (int k = 0; k < N; k++) begin
            w_strb[k] = !w_err && (4'(k) >= w_lane) && (4'(k) < (w_lane + w_bytes));
        end

        w_data          = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_data[i] = !w_err && (7'(i) < {w_bytes, 3'b000}) && w_shifted[i];
        end

        // Lane k takes source byte k mod B; oversized accesses pass the value straight through.
        w_wdata         = '0;
        for (int k = 0; k < N; k++) begin
            w_wdata[8*k +: 8] = wdata_in[8*(w_too_big ? k : (k & int'(w_bmask))) +: 8];
        end
    end

    generate
        if (OUTPUT_REG) begin : g_reg
            logic [ADDR_WIDTH-1:0] r_addr;
            logic [N-1:0]          r_strb;
            logic [DATA_WIDTH-1:0] r_data;
            logic [DATA_WIDTH-1:0] r_wdata;
            logic                  r_err;

            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    r_addr  <= '0;
                    r_strb  <= '0;
                    r_data  <= '0;
                    r_wdata <= '0;
                    r_err   <= 1'b0;
                end else begin
                    r_addr  <= w_addr;
                    r_strb  <= w_strb;
                    r_data  <= w_data;
                    r_wdata <= w_wdata;
                    r_err   <= w_err;
                end
            end

            assign addr_out  = r_addr;
            assign strb      = r_strb;
            assign data_out  = r_data;
            assign wdata_out = r_wdata;
            assign err       = r_err;
        end else begin : g_comb
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = aclk | areset;

            assign addr_out  = w_addr;
            assign strb      = w_strb;
            assign data_out  = w_data;
            assign wdata_out = w_wdata;
            assign err       = w_err;
        end
    endgenerate
endmodule

// File: tb/tb_axi_byte_lane_addresser.sv
// Directed checks of the lane addresser: 64-bit combinational, 32-bit combinational, 64-bit registered.
module tb_axi_byte_lane_addresser;
    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] addr_in;
    logic [1:0]  size;
    logic [63:0] data_in, wdata_in;
    logic [31:0] d32_in, wd32_in;

    logic [31:0] c_addr;  logic [7:0] c_strb;  logic [63:0] c_data, c_wdata;  logic c_err;
    logic [31:0] n_addr;  logic [3:0] n_strb;  logic [31:0] n_data, n_wdata;  logic n_err;
    logic [31:0] q_addr;  logic [7:0] q_strb;  logic [63:0] q_data, q_wdata;  logic q_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    axi_byte_lane_addresser #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .OUTPUT_REG(1'b0)) u_c64 (
        .aclk(aclk), .areset(areset), .addr_in(addr_in), .size(size),
        .data_in(data_in), .wdata_in(wdata_in), .addr_out(c_addr), .strb(c_strb),
        .data_out(c_data), .wdata_out(c_wdata), .err(c_err));

    axi_byte_lane_addresser #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .OUTPUT_REG(1'b0)) u_c32 (
        .aclk(aclk), .areset(areset), .addr_in(addr_in), .size(size),
        .data_in(d32_in), .wdata_in(wd32_in), .addr_out(n_addr), .strb(n_strb),
        .data_out(n_data), .wdata_out(n_wdata), .err(n_err));

    axi_byte_lane_addresser #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .OUTPUT_REG(1'b1)) u_r64 (
        .aclk(aclk), .areset(areset), .addr_in(addr_in), .size(size),
        .data_in(data_in), .wdata_in(wdata_in), .addr_out(q_addr), .strb(q_strb),
        .data_out(q_data), .wdata_out(q_wdata), .err(q_err));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q_zero(input string tag);
        chk({tag, "_addr"},  64'(q_addr), 64'h0);
        chk({tag, "_strb"},  64'(q_strb), 64'h0);
        chk({tag, "_data"},  q_data,      64'h0);
        chk({tag, "_wdata"}, q_wdata,     64'h0);
        chk({tag, "_err"},   64'(q_err),  64'h0);
    endtask

    initial begin
        areset   = 1'b1;
        addr_in  = 32'h0;
        size     = 2'd0;
        data_in  = 64'h8877_6655_4433_2211;
        wdata_in = 64'h0;
        d32_in   = 32'h4433_2211;
        wd32_in  = 32'hCAFE_F00D;
        #2;
        chk_q_zero("rst");

        // 64-bit combinational
        addr_in = 32'h1000_0005; size = 2'd0; wdata_in = 64'hA5; #1;
        chk("b5_addr",  64'(c_addr), 64'h1000_0000);
        chk("b5_strb",  64'(c_strb), 64'h20);
        chk("b5_data",  c_data,      64'h66);
        chk("b5_wdata", c_wdata,     64'hA5A5_A5A5_A5A5_A5A5);
        chk("b5_err",   64'(c_err),  64'h0);

        for (int a = 0; a < 8; a++) begin
            addr_in = 32'h2000_0000 | 32'(a); size = 2'd0; #1;
            chk("sweep_strb", 64'(c_strb), 64'h1 << a);
            chk("sweep_data", c_data,      64'(a + 1) * 64'h11);
            chk("sweep_err",  64'(c_err),  64'h0);
        end

        addr_in = 32'h0000_0004; size = 2'd2; wdata_in = 64'hDEAD_BEEF; #1;
        chk("w4_strb",  64'(c_strb), 64'hF0);
        chk("w4_data",  c_data,      64'h8877_6655);
        chk("w4_wdata", c_wdata,     64'hDEAD_BEEF_DEAD_BEEF);
        chk("w4_err",   64'(c_err),  64'h0);

        addr_in = 32'h0000_0006; size = 2'd2; #1;
        chk("w6_err",  64'(c_err),  64'h1);
        chk("w6_strb", 64'(c_strb), 64'h0);
        chk("w6_data", c_data,      64'h0);
        chk("w6_addr", 64'(c_addr), 64'h0);

        addr_in = 32'h0000_0002; size = 2'd1; wdata_in = 64'h1234; #1;
        chk("h2_strb",  64'(c_strb), 64'h0C);
        chk("h2_data",  c_data,      64'h4433);
        chk("h2_wdata", c_wdata,     64'h1234_1234_1234_1234);

        addr_in = 32'h0000_0003; size = 2'd1; #1;
        chk("h3_err",  64'(c_err),  64'h1);
        chk("h3_strb", 64'(c_strb), 64'h0);

        addr_in = 32'h0000_0008; size = 2'd3; wdata_in = 64'h0102_0304_0506_0708; #1;
        chk("d8_strb",  64'(c_strb), 64'hFF);
        chk("d8_data",  c_data,      64'h8877_6655_4433_2211);
        chk("d8_wdata", c_wdata,     64'h0102_0304_0506_0708);
        chk("d8_addr",  64'(c_addr), 64'h8);

        addr_in = 32'h0000_0004; size = 2'd3; #1;
        chk("d4_err",  64'(c_err),  64'h1);
        chk("d4_data", c_data,      64'h0);

        // 32-bit combinational
        addr_in = 32'h0000_0000; size = 2'd3; #1;
        chk("n_d_err",   64'(n_err),   64'h1);
        chk("n_d_strb",  64'(n_strb),  64'h0);
        chk("n_d_wdata", 64'(n_wdata), 64'hCAFE_F00D);

        addr_in = 32'h0000_0003; size = 2'd0; #1;
        chk("n_b3_addr",  64'(n_addr),  64'h0);
        chk("n_b3_strb",  64'(n_strb),  64'h8);
        chk("n_b3_data",  64'(n_data),  64'h44);
        chk("n_b3_wdata", 64'(n_wdata), 64'h0D0D_0D0D);

        addr_in = 32'h0000_0006; size = 2'd1; #1;
        chk("n_h6_strb", 64'(n_strb), 64'hC);
        chk("n_h6_data", 64'(n_data), 64'h4433);

        // 64-bit registered
        @(negedge aclk);
        areset = 1'b0; addr_in = 32'h0; size = 2'd0; wdata_in = 64'hA5;
        @(posedge aclk); #1;
        chk("q0_strb", 64'(q_strb), 64'h01);
        chk("q0_data", q_data,      64'h11);

        @(negedge aclk);
        addr_in = 32'h1000_0005; #1;
        chk("q_hold_strb", 64'(q_strb), 64'h01);
        chk("q_hold_addr", 64'(q_addr), 64'h0);
        @(posedge aclk); #1;
        chk("q5_strb",  64'(q_strb), 64'h20);
        chk("q5_data",  q_data,      64'h66);
        chk("q5_addr",  64'(q_addr), 64'h1000_0000);
        chk("q5_wdata", q_wdata,     64'hA5A5_A5A5_A5A5_A5A5);

        #2 areset = 1'b1;
        #1 chk_q_zero("qrst_async");
        @(posedge aclk); #1;
        chk_q_zero("qrst_held");
        @(negedge aclk);
        areset = 1'b0; #1;
        chk("qrel_strb", 64'(q_strb), 64'h0);
        @(posedge aclk); #1;
        chk("qrec_strb", 64'(q_strb), 64'h20);
        chk("qrec_addr", 64'(q_addr), 64'h1000_0000);
        chk("qrec_data", q_data,      64'h66);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
